// File: rtl/tb_tohost_monitor.sv
// Simulation-side monitor on the data-memory write port: decodes tohost pass/fail
// and console stores, buffers console characters, and runs a retire-based watchdog.
module tb_tohost_monitor #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 64,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h8000_1000,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h8000_1008,
    parameter int unsigned       TIMEOUT      = 200000,
    parameter int unsigned       FIFO_DEPTH   = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit_valid,
    output logic              chr_valid,
    input  logic              chr_ready,
    output logic [7:0]        chr_data,
    output logic              done,
    output logic              pass,
    output logic [30:0]       fail_code,
    output logic              timeout,
    output logic              quiesce,
    output logic [63:0]       cycle_cnt
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    typedef enum logic {RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic            tohost_hit, expire;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Back-pressure only console stores; a simultaneous pop does not free the slot early.
    assign wr_ready  = !((wr_addr == CONSOLE_ADDR) && fifo_full);
    assign push      = wr_valid && wr_ready && (wr_addr == CONSOLE_ADDR);
    assign pop       = chr_valid && chr_ready;
    assign chr_valid = !fifo_empty;
    assign chr_data  = mem[rd_ptr[AW-1:0]];

    assign done    = (state == DONE);
    assign quiesce = done && fifo_empty;

    always_comb begin
        state_nxt  = state;
        tohost_hit = 1'b0;
        expire     = 1'b0;
        if (state == RUN) begin
            tohost_hit = wr_valid && wr_ready && (wr_addr == TOHOST_ADDR) && wr_data[0];
            expire     = !commit_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
            if (tohost_hit || expire) begin
                state_nxt = DONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Flags are only written from RUN, so they freeze once the test is decided.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pass      <= 1'b0;
            fail_code <= '0;
            timeout   <= 1'b0;
            wd_cnt    <= '0;
            cycle_cnt <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            wd_cnt    <= commit_valid ? '0 : wd_cnt + WD_W'(1);
            if (tohost_hit) begin
                pass      <= (wr_data == DATA_W'(1));
                fail_code <= (wr_data == DATA_W'(1)) ? '0 : wr_data[31:1];
            end else if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data[7:0];
        end
    end

endmodule

// File: tb/tb_tb_tohost_monitor.sv
// Bench for tb_tohost_monitor: directed scenarios plus randomized episodes, all
// checked every cycle against a queue-based reference model of the monitor.
module tb_tb_tohost_monitor;

    localparam logic [31:0] TOHOST  = 32'h8000_1000;
    localparam logic [31:0] CONSOLE = 32'h8000_1008;
    localparam logic [31:0] OTHER   = 32'h8000_2000;
    localparam int unsigned TMO     = 8;
    localparam int unsigned DEPTH   = 16;

    logic        CLK;
    logic        RSTn;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        commit_valid;
    logic        chr_valid;
    logic        chr_ready;
    logic [7:0]  chr_data;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        timeout;
    logic        quiesce;
    logic [63:0] cycle_cnt;

    tb_tohost_monitor #(
        .ADDR_W      (32),
        .DATA_W      (64),
        .TOHOST_ADDR (TOHOST),
        .CONSOLE_ADDR(CONSOLE),
        .TIMEOUT     (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_valid(commit_valid),
        .chr_valid   (chr_valid),
        .chr_ready   (chr_ready),
        .chr_data    (chr_data),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .timeout     (timeout),
        .quiesce     (quiesce),
        .cycle_cnt   (cycle_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [7:0]  q[$];
    logic        m_done, m_pass, m_tmo;
    logic [30:0] m_fail;
    logic [63:0] m_cyc;
    int unsigned m_idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        m_tmo  = 1'b0;
        m_fail = '0;
        m_cyc  = '0;
        m_idle = 0;
    endtask

    task automatic check_reset_outs();
        check("rst_done",      done,      64'd0);
        check("rst_pass",      pass,      64'd0);
        check("rst_timeout",   timeout,   64'd0);
        check("rst_fail_code", fail_code, 64'd0);
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_chr_valid", chr_valid, 64'd0);
        check("rst_quiesce",   quiesce,   64'd0);
        check("rst_wr_ready",  wr_ready,  64'd1);
    endtask

    // Called at a falling edge; drives inputs, checks outputs, advances the model
    // over the coming rising edge and returns at the next falling edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [63:0] d,
                        input logic c, input logic r);
        logic exp_rdy, acc;
        wr_valid     = v;
        wr_addr      = a;
        wr_data      = d;
        commit_valid = c;
        chr_ready    = r;
        #1;
        exp_rdy = !((a == CONSOLE) && (q.size() == DEPTH));
        check("wr_ready",  wr_ready,  exp_rdy);
        check("chr_valid", chr_valid, q.size() != 0);
        if (q.size() != 0) check("chr_data", chr_data, q[0]);
        check("done",      done,      m_done);
        check("pass",      pass,      m_pass);
        check("fail_code", fail_code, m_fail);
        check("timeout",   timeout,   m_tmo);
        check("quiesce",   quiesce,   m_done && (q.size() == 0));
        check("cycle_cnt", cycle_cnt, m_cyc);

        acc = v && exp_rdy;
        if (!m_done) begin
            m_cyc  = m_cyc + 64'd1;
            m_idle = c ? 0 : m_idle + 1;
            if (acc && (a == TOHOST) && d[0]) begin
                m_done = 1'b1;
                m_pass = (d == 64'd1);
                m_fail = m_pass ? 31'd0 : d[31:1];
            end else if (m_idle >= TMO) begin
                m_done = 1'b1;
                m_tmo  = 1'b1;
            end
        end
        if (r && (q.size() != 0)) void'(q.pop_front());
        if (acc && (a == CONSOLE)) q.push_back(d[7:0]);
        @(negedge CLK);
    endtask

    // Asserted between edges so the check shows the reset acting asynchronously.
    task automatic do_reset();
        #2 RSTn = 1'b0;
        #1;
        check_reset_outs();
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        int unsigned sel, cpct, rpct;

        RSTn = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit_valid = 1'b0;
        chr_ready = 1'b0;
        model_reset();
        @(negedge CLK);
        check_reset_outs();
        @(negedge CLK);
        RSTn = 1'b1;

        // Idle run: cycle counter counts up from 1
        for (int i = 0; i < 5; i++) step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        check("cyc_after_5", cycle_cnt, 64'd5);

        // Even tohost values ignored, then pass
        step(1'b1, TOHOST, 64'd0, 1'b1, 1'b0);
        step(1'b1, TOHOST, 64'd2, 1'b1, 1'b0);
        step(1'b1, TOHOST, 64'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        check("pass_dir",    pass,    64'd1);
        check("quiesce_dir", quiesce, 64'd1);
        do_reset();

        // Fail code, later pass store has no effect
        step(1'b1, TOHOST, 64'd7, 1'b1, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        step(1'b1, TOHOST, 64'd1, 1'b1, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        check("fail_code_dir", fail_code, 64'd3);
        check("fail_pass_dir", pass,      64'd0);
        do_reset();

        // Console FIFO fill, back-pressure and drain across pointer wrap
        for (int i = 0; i < 17; i++) step(1'b1, CONSOLE, 64'(65 + i), 1'b1, 1'b0);
        step(1'b1, CONSOLE, 64'(65 + 16), 1'b1, 1'b1);
        step(1'b1, CONSOLE, 64'(65 + 16), 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, OTHER, 64'd0, 1'b1, 1'b1);
        check("fifo_drained", chr_valid, 64'd0);
        do_reset();

        // Watchdog expiry with no commits; counter frozen afterwards
        for (int i = 0; i < 12; i++) step(1'b0, OTHER, 64'd0, 1'b0, 1'b0);
        check("timeout_dir", timeout,   64'd1);
        check("cyc_frozen",  cycle_cnt, 64'd8);
        do_reset();

        // Commit every fifth cycle never expires
        for (int i = 0; i < 40; i++) step(1'b0, OTHER, 64'd0, (i % 5) == 4, 1'b0);
        check("no_timeout", done, 64'd0);
        do_reset();

        // Pass store on the expiry cycle wins
        for (int i = 0; i < 7; i++) step(1'b0, OTHER, 64'd0, 1'b0, 1'b0);
        step(1'b1, TOHOST, 64'd1, 1'b0, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b0, 1'b0);
        check("tie_pass",    pass,    64'd1);
        check("tie_timeout", timeout, 64'd0);
        do_reset();

        // Drain after done, then reset mid-drain
        step(1'b1, CONSOLE, 64'h78, 1'b1, 1'b0);
        step(1'b1, CONSOLE, 64'h79, 1'b1, 1'b0);
        step(1'b1, CONSOLE, 64'h7a, 1'b1, 1'b0);
        step(1'b1, TOHOST,  64'd1,  1'b1, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, OTHER, 64'd0, 1'b1, 1'b1);
        check("quiesce_drain", quiesce, 64'd1);
        step(1'b1, CONSOLE, 64'h6d, 1'b1, 1'b0);
        step(1'b1, CONSOLE, 64'h6e, 1'b1, 1'b0);
        step(1'b0, OTHER, 64'd0, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, OTHER, 64'd0, 1'b1, 1'b1);

        // Randomized episodes
        for (int ep = 0; ep < 12; ep++) begin
            cpct = $urandom_range(55, 100);
            rpct = $urandom_range(0, 100);
            for (int i = 0; i < 150; i++) begin
                sel = $urandom_range(0, 19);
                d = {$urandom, $urandom};
                if (sel == 0) begin
                    a = TOHOST;
                    case ($urandom_range(0, 3))
                        0:       d = 64'd1;
                        1:       d[0] = 1'b1;
                        2:       d[0] = 1'b0;
                        default: d = 64'd0;
                    endcase
                end else if (sel == 1) begin
                    a = TOHOST + 32'd4;
                end else if (sel < 12) begin
                    a = CONSOLE;
                end else begin
                    a = $urandom;
                end
                step($urandom_range(0, 3) != 0, a, d,
                     $urandom_range(1, 100) <= cpct, $urandom_range(1, 100) <= rpct);
            end
            do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
